// File: rtl/program_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : program_loader_if                                            |
// | Description : Byte-stream handshake plus instruction-memory programming    |
// |               bus shared between an upstream byte source, the loader and   |
// |               instr_fetch.                                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface program_loader_if #(
  parameter int ADDR_W = 9
) ();

  // Byte stream (valid/ready, transfer = in_valid & in_ready)
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;

  // Instruction-memory programming port
  logic              program_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       program_instr;
  logic              stall_en;

  // Upstream side: drives the byte stream, observes everything else
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  program_en,
    input  addr,
    input  program_instr,
    input  stall_en
  );

  // Loader side: consumes bytes and drives the programming port
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output program_en,
    output addr,
    output program_instr,
    output stall_en
  );

endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : program_loader                                               |
// | Description : Receives a length-prefixed byte stream, assembles            |
// |               little-endian 32-bit words and writes them to consecutive    |
// |               instruction addresses from 0, holding the core stalled       |
// |               until the whole image has been written.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module program_loader #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  program_loader_if.slave   bus,
  input  logic              reload,
  output logic              loaded,
  output logic              err
);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_WORD   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [15:0]       c_depth    = 16'(DEPTH);
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  state_t            r_state;
  state_t            w_next;

  logic [15:0]       r_count;
  logic [1:0]        r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_instr;

  logic              w_ready;
  logic              w_pen;
  logic              w_loaded;
  logic              w_stall;
  logic              w_err;
  logic              w_xfer;
  logic [15:0]       w_len;
  logic              w_len_bad;
  logic              w_last;

  // A byte is consumed only when both sides agree in the same cycle
  assign w_xfer    = bus.in_valid & w_ready;

  // Full word count as it will stand once the high length byte lands
  assign w_len     = {bus.in_data, r_count[7:0]};
  // Zero-length and oversize images are rejected before any write happens
  assign w_len_bad = (w_len == 16'd0) || (w_len > c_depth);

  // The word being written is the last one of the image
  assign w_last    = (16'(r_addr) == (r_count - 16'd1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LEN_LO;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-state handshake/strobe outputs
  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_pen    = 1'b0;
    w_loaded = 1'b0;
    w_stall  = 1'b1;
    w_err    = 1'b0;
    case (r_state)
      S_LEN_LO: begin
        w_ready = 1'b1;
        if (bus.in_valid) begin
          w_next = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        w_ready = 1'b1;
        if (bus.in_valid) begin
          w_next = w_len_bad ? S_ERR : S_WORD;
        end
      end
      S_WORD: begin
        w_ready = 1'b1;
        if (bus.in_valid && (r_idx == 2'd3)) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        // Upstream is paused for the single commit cycle
        w_pen  = 1'b1;
        w_next = w_last ? S_DONE : S_WORD;
      end
      S_DONE: begin
        w_loaded = 1'b1;
        w_next   = S_RUN;
      end
      S_RUN: begin
        w_stall = 1'b0;
        if (reload) begin
          w_next = S_LEN_LO;
        end
      end
      S_ERR: begin
        // Keep draining so the byte source never blocks behind a bad frame
        w_ready = 1'b1;
        w_err   = 1'b1;
        if (reload) begin
          w_next = S_LEN_LO;
        end
      end
      default: begin
        w_next = S_LEN_LO;
      end
    endcase
  end

  // Length capture, byte assembly and write-address sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 16'd0;
      r_idx   <= 2'd0;
      r_addr  <= '0;
      r_instr <= 32'd0;
    end else begin
      case (r_state)
        S_LEN_LO: begin
          if (w_xfer) begin
            r_count[7:0] <= bus.in_data;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_count[15:8] <= bus.in_data;
            r_idx         <= 2'd0;
            r_addr        <= '0;
          end
        end
        S_WORD: begin
          // Unreceived byte lanes keep their previous contents
          if (w_xfer) begin
            r_instr[8*r_idx +: 8] <= bus.in_data;
            r_idx                 <= r_idx + 2'd1;
          end
        end
        S_WRITE: begin
          // Final address is held so addr never wraps past DEPTH-1
          if (!w_last) begin
            r_addr <= r_addr + c_addr_one;
            r_idx  <= 2'd0;
          end
        end
        S_RUN, S_ERR: begin
          if (reload) begin
            r_addr <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready      = w_ready;
  assign bus.program_en    = w_pen;
  assign bus.addr          = r_addr;
  assign bus.program_instr = r_instr;
  assign bus.stall_en      = w_stall;
  assign loaded            = w_loaded;
  assign err               = w_err;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_program_loader                                            |
// | Description : Directed self-checking bench for program_loader.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_program_loader;

  logic clk;
  logic rst_n;
  logic reload;
  logic loaded;
  logic err;

  int vectors;
  int miscompares;
  int loaded_cnt;
  logic prev_pen;

  logic [8:0]  wa[$];
  logic [31:0] wd[$];

  program_loader_if #(.ADDR_W(9)) bus ();

  program_loader #(.ADDR_W(9), .DEPTH(512)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .reload (reload),
    .loaded (loaded),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/strobe observer, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pen = 1'b0;
    end else begin
      if (bus.program_en === 1'b1) begin
        wa.push_back(bus.addr);
        wd.push_back(bus.program_instr);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL write_ready: in_ready=%b during write, required 0", bus.in_ready);
        end
        vectors++;
        if (prev_pen) begin
          miscompares++;
          $display("FAIL pen_consecutive: program_en high two cycles, required single pulse");
        end
      end
      if (loaded === 1'b1) loaded_cnt++;
      prev_pen = bus.program_en;
    end
  end

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    loaded_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_timeout: in_ready=%b for 200 cycles, required 1", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.stall_en !== 1'b1) begin miscompares++; $display("FAIL rst_stall: got %b, required 1", bus.stall_en); end
    vectors++; if (bus.program_en !== 1'b0) begin miscompares++; $display("FAIL rst_pen: got %b, required 0", bus.program_en); end
    vectors++; if (bus.addr !== 9'd0) begin miscompares++; $display("FAIL rst_addr: got %0d, required 0", bus.addr); end
    vectors++; if (bus.program_instr !== 32'd0) begin miscompares++; $display("FAIL rst_instr: got %h, required 0", bus.program_instr); end
    vectors++; if (loaded !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL rst_flags: loaded=%b err=%b, required 0 0", loaded, err); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b, required 1", bus.in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_n2();
    logic [7:0] bytes [0:9];
    bytes = '{8'h02, 8'h00, 8'hB7, 8'h00, 8'hA0, 8'h00, 8'hD7, 8'h00, 8'h30, 8'h00};
    clear_mon();
    for (int i = 0; i < 10; i++) send_byte(bytes[i], 0);
    @(negedge clk);
    vectors++; if (bus.program_en !== 1'b1 || bus.addr !== 9'd1 || bus.program_instr !== 32'h003000d7) begin
      miscompares++; $display("FAIL n2_lastwrite: pen=%b addr=%0d data=%h, required 1 1 003000d7", bus.program_en, bus.addr, bus.program_instr); end
    @(negedge clk);
    vectors++; if (loaded !== 1'b1 || bus.stall_en !== 1'b1) begin
      miscompares++; $display("FAIL n2_loaded: loaded=%b stall=%b, required 1 1", loaded, bus.stall_en); end
    @(negedge clk);
    vectors++; if (bus.stall_en !== 1'b0 || bus.in_ready !== 1'b0 || loaded !== 1'b0) begin
      miscompares++; $display("FAIL n2_run: stall=%b ready=%b loaded=%b, required 0 0 0", bus.stall_en, bus.in_ready, loaded); end
    vectors++; if (wa.size() != 2 || loaded_cnt != 1) begin
      miscompares++; $display("FAIL n2_count: writes=%0d loaded=%0d, required 2 1", wa.size(), loaded_cnt); end
    else begin
      vectors++; if (wa[0] !== 9'd0 || wd[0] !== 32'h00a000b7) begin
        miscompares++; $display("FAIL n2_word0: addr=%0d data=%h, required 0 00a000b7", wa[0], wd[0]); end
      vectors++; if (wa[1] !== 9'd1 || wd[1] !== 32'h003000d7) begin
        miscompares++; $display("FAIL n2_word1: addr=%0d data=%h, required 1 003000d7", wa[1], wd[1]); end
    end
  endtask

  task automatic test_reload();
    clear_mon();
    pulse_reload();
    vectors++; if (bus.stall_en !== 1'b1 || err !== 1'b0 || bus.addr !== 9'd0) begin
      miscompares++; $display("FAIL rl_restart: stall=%b err=%b addr=%0d, required 1 0 0", bus.stall_en, err, bus.addr); end
    send_len(16'd1);
    send_word(32'hFFF000F7, 0);
    repeat (3) @(negedge clk);
    vectors++; if (wa.size() != 1) begin
      miscompares++; $display("FAIL rl_count: writes=%0d, required 1", wa.size()); end
    else begin
      vectors++; if (wa[0] !== 9'd0 || wd[0] !== 32'hFFF000F7) begin
        miscompares++; $display("FAIL rl_word: addr=%0d data=%h, required 0 fff000f7", wa[0], wd[0]); end
    end
    vectors++; if (bus.stall_en !== 1'b0 || err !== 1'b0 || loaded_cnt != 1) begin
      miscompares++; $display("FAIL rl_done: stall=%b err=%b loaded=%0d, required 0 0 1", bus.stall_en, err, loaded_cnt); end
  endtask

  task automatic test_back_to_back_gaps();
    logic [31:0] img [0:13];
    img = '{32'h00a000b7, 32'h003000d7, 32'h00100093, 32'h00200113, 32'h002081b3,
            32'h40208233, 32'h0020f2b3, 32'h0020e333, 32'h0020c3b3, 32'h00209433,
            32'h0020d4b3, 32'h4020d533, 32'h00302023, 32'h0000001f};
    clear_mon();
    pulse_reload();
    send_len(16'd14);
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 4; k++) send_byte(img[i][8*k +: 8], int'($urandom_range(0, 3)));
    end
    repeat (3) @(negedge clk);
    vectors++; if (wa.size() != 14 || loaded_cnt != 1) begin
      miscompares++; $display("FAIL gap_count: writes=%0d loaded=%0d, required 14 1", wa.size(), loaded_cnt); end
    else begin
      for (int i = 0; i < 14; i++) begin
        vectors++; if (wa[i] !== 9'(i) || wd[i] !== img[i]) begin
          miscompares++; $display("FAIL gap_word%0d: addr=%0d data=%h, required %0d %h", i, wa[i], wd[i], i, img[i]); end
      end
    end
  endtask

  task automatic test_len_errors();
    clear_mon();
    pulse_reload();
    send_len(16'd0);
    @(negedge clk);
    vectors++; if (err !== 1'b1 || bus.stall_en !== 1'b1 || bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL len0_err: err=%b stall=%b ready=%b, required 1 1 1", err, bus.stall_en, bus.in_ready); end
    send_word(32'hDEADBEEF, 0);
    @(negedge clk);
    vectors++; if (wa.size() != 0 || err !== 1'b1) begin
      miscompares++; $display("FAIL len0_drain: writes=%0d err=%b, required 0 1", wa.size(), err); end
    pulse_reload();
    vectors++; if (err !== 1'b0 || bus.stall_en !== 1'b1) begin
      miscompares++; $display("FAIL err_reload: err=%b stall=%b, required 0 1", err, bus.stall_en); end
    send_len(16'd513);
    @(negedge clk);
    vectors++; if (err !== 1'b1) begin
      miscompares++; $display("FAIL len513_err: err=%b, required 1", err); end
    send_word(32'h01020304, 0);
    @(negedge clk);
    vectors++; if (wa.size() != 0 || err !== 1'b1 || bus.stall_en !== 1'b1) begin
      miscompares++; $display("FAIL len513_drain: writes=%0d err=%b stall=%b, required 0 1 1", wa.size(), err, bus.stall_en); end
  endtask

  task automatic test_async_reset();
    pulse_reload();
    send_len(16'd4);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    send_word(32'h33333333, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    vectors++; if (bus.addr !== 9'd3 || bus.program_instr !== 32'h3333BBAA) begin
      miscompares++; $display("FAIL ar_pre: addr=%0d data=%h, required 3 3333bbaa", bus.addr, bus.program_instr); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (bus.addr !== 9'd0 || bus.program_instr !== 32'd0 || bus.stall_en !== 1'b1 ||
                   bus.program_en !== 1'b0 || loaded !== 1'b0 || err !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL ar_async: addr=%0d data=%h stall=%b pen=%b loaded=%b err=%b ready=%b, required 0 0 1 0 0 0 1",
                              bus.addr, bus.program_instr, bus.stall_en, bus.program_en, loaded, err, bus.in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    send_len(16'd1);
    send_word(32'h12345678, 0);
    repeat (3) @(negedge clk);
    vectors++; if (wa.size() != 1 || loaded_cnt != 1) begin
      miscompares++; $display("FAIL ar_reload_count: writes=%0d loaded=%0d, required 1 1", wa.size(), loaded_cnt); end
    else begin
      vectors++; if (wa[0] !== 9'd0 || wd[0] !== 32'h12345678) begin
        miscompares++; $display("FAIL ar_reload_word: addr=%0d data=%h, required 0 12345678", wa[0], wd[0]); end
    end
  endtask

  task automatic test_max_length();
    int bad;
    clear_mon();
    pulse_reload();
    send_len(16'd512);
    for (int i = 0; i < 512; i++) begin
      // reload outside RUN/ERR must have no effect
      if (i == 5) pulse_reload();
      send_word(32'(i), 0);
    end
    repeat (3) @(negedge clk);
    vectors++; if (wa.size() != 512 || loaded_cnt != 1) begin
      miscompares++; $display("FAIL max_count: writes=%0d loaded=%0d, required 512 1", wa.size(), loaded_cnt); end
    else begin
      bad = 0;
      for (int i = 0; i < 512; i++) if (wa[i] !== 9'(i) || wd[i] !== 32'(i)) bad++;
      vectors++; if (bad != 0) begin
        miscompares++; $display("FAIL max_sequence: %0d bad writes, required 0", bad); end
      vectors++; if (wa[511] !== 9'd511 || wd[511] !== 32'd511) begin
        miscompares++; $display("FAIL max_last: addr=%0d data=%h, required 511 000001ff", wa[511], wd[511]); end
    end
    vectors++; if (bus.addr !== 9'd511 || bus.stall_en !== 1'b0) begin
      miscompares++; $display("FAIL max_hold: addr=%0d stall=%b, required 511 0", bus.addr, bus.stall_en); end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    loaded_cnt   = 0;
    prev_pen     = 1'b0;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_load_n2();
    test_reload();
    test_back_to_back_gaps();
    test_len_errors();
    test_async_reset();
    test_max_length();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
